// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Valid/ready byte channel carrying received UART bytes.
//               master : producer side (drives data/valid, observes ready)
//               slave  : consumer side (observes data/valid, drives ready)
//   data  [7:0]  received byte, stable while valid is high
//   valid        data holds an unconsumed byte
//   ready        consumer accepts data on any cycle where valid && ready
// Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first. Synchronises rx, finds the
//               start bit, samples every bit at its centre, checks the stop
//               bit and delivers each good byte into a valid/ready holding
//               register.
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   rx            asynchronous serial input, idles high
//   out_if        valid/ready byte output (master modport)
//   frame_err     one-cycle pulse: stop bit low, byte discarded
//   overrun       one-cycle pulse: good byte while holding register full and
//                 not being read, new byte discarded
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    input  wire logic   rx,
    uart_rx_if.master   out_if,
    output logic        frame_err,
    output logic        overrun
);

    localparam logic [15:0] c_half_last = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_bit_last  = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic        s1_q,        s1_d;
    logic        s2_q,        s2_d;
    logic        s2_prev_q,   s2_prev_d;
    logic [15:0] cnt_q,       cnt_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    logic [7:0]  shift_q,     shift_d;
    logic [7:0]  data_q,      data_d;
    logic        valid_q,     valid_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q,   overrun_d;

    always_comb begin
        s1_d        = rx;
        s2_d        = s1_q;
        s2_prev_d   = s2_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Consume; a load on the same edge (below) overrides this.
        if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // Edge-triggered so a held-low break cannot retrigger.
                if (s2_prev_q && !s2_q) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end

            START: begin
                if (cnt_q == c_half_last) begin
                    cnt_d = 16'd0;
                    if (s2_q) begin
                        state_d = IDLE;          // too short: a glitch
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_q == c_bit_last) begin
                    cnt_d             = 16'd0;
                    shift_d[bit_idx_q] = s2_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (cnt_q == c_bit_last) begin
                    // Back to IDLE at the stop centre so a start bit half a
                    // bit later is still caught.
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (!s2_q) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || out_if.ready) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b1;
            s2_q        <= 1'b1;
            s2_prev_q   <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s2_prev_q   <= s2_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_if.data  = data_q;
    assign out_if.valid = valid_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, 8N1, LSB first: the receiving end of the same link `uart_tx` drives. It synchronises the asynchronous `rx` line, detects the start bit, samples each bit at its centre, and checks the stop bit. It presents each received byte on a valid/ready output holding register. Framing errors and overruns are reported as single-cycle pulses.

## Interface

- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range 4..65535. `HALF = CLKS_PER_BIT/2`, rounded down.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial input; asynchronous to `clk`; idles high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on any cycle where `valid && ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low, byte discarded.
- `overrun`  out  1  one-cycle pulse: good byte arrived while the holding register was full and not being read; new byte discarded.

## Operation

- **Synchroniser.** Two flops, `s1` then `s2`, both reset to 1. A third flop, `s2_prev`, holds the previous `s2` and also resets to 1. All decisions use `s2`.
- **Reset values.**
  - Outputs: `data` 0x00, `valid` 0, `frame_err` 0, `overrun` 0.
  - Internal: state IDLE, bit counter 0, cycle counter 0, shift register 0.
- **FSM states.** IDLE, START, DATA, STOP.
  - **IDLE:** a falling edge (`s2_prev==1 && s2==0`) moves the FSM to START with the cycle counter at 0. A level low alone does not trigger; a held-low break is received at most once.
  - **START:** the counter increments each cycle. When counter == HALF-1, `s2` is sampled.
    - `s2==1`: glitch. Return to IDLE with no output.
    - `s2==0`: go to DATA, counter 0, bit index 0.
  - **DATA:** when counter == CLKS_PER_BIT-1, sample `s2` into shift bit `[bit index]` (LSB first) and reset the counter. After bit index 7 is sampled, go to STOP.
  - **STOP:** when counter == CLKS_PER_BIT-1, sample `s2`, then go to IDLE.
    - `s2==1`: good byte; apply the delivery rule below.
    - `s2==0`: pulse `frame_err`; discard the byte.
- **Delivery rule** (evaluated on the clock edge of the stop sample):
  - `valid==0`, or `valid && ready`: load `data` from the shift register and set `valid=1`.
  - `valid && !ready`: pulse `overrun`. `data` and `valid` are unchanged.
- **Consume.** When `valid && ready` and no load occurs on that edge, clear `valid`. `data` keeps its value.
- **Arithmetic.** The cycle counter is 16 bits and the bit index is 3 bits. Neither counter ever wraps past its terminal value.
- **Back-to-back frames.** The FSM returns to IDLE at the stop-bit centre, so a start bit arriving HALF cycles later is caught.
- **Reset mid-frame.** Asserting `rst_n` at any time aborts the frame. All reset values apply immediately, with no wait for a clock edge.

## Timing

- E is the clock edge at which `s2` is first 0 after being 1. E occurs 2 edges after `rx` is first sampled low.
- Sample points:
  - start bit at E+HALF;
  - data bit k (k = 0..7) at E+HALF+(k+1)·CLKS_PER_BIT;
  - stop bit at E+HALF+9·CLKS_PER_BIT.
- `valid`, `frame_err` and `overrun` change on the stop-sample edge. `frame_err` and `overrun` are high for exactly one cycle.
- Pin-to-`valid` latency: HALF + 9·CLKS_PER_BIT + 2 clocks.
- Throughput: one byte per 10·CLKS_PER_BIT cycles. A consumer must accept within 10·CLKS_PER_BIT − 1 cycles to avoid overrun.

## Test plan

All scenarios use CLKS_PER_BIT=16 and `ready=1` unless stated.

1. **Basic byte.** Frame 0x55, `ready=0`. `valid` rises at E+152 and `data`=0x55. Raising `ready` for one cycle clears `valid`.
2. **Start glitch.** `rx` low for 4 cycles, then high. No `valid`, no `frame_err`. A subsequent 0xA5 frame is received correctly.
3. **Framing error.** 0xA3 with stop bit 0. `frame_err` pulses once at E+152 and `valid` stays 0. Line held low 40 cycles, then high, then 0x3C: exactly one byte 0x3C, no second `frame_err`.
4. **Overrun.** Two back-to-back frames 0x11 then 0x22 with `ready=0`. `overrun` pulses at the second stop sample and `data` stays 0x11. With `ready=1` asserted exactly on the second stop-sample edge instead: no `overrun`, `data`=0x22, `valid` stays 1.
5. **Reset mid-frame.** `rst_n` low for 3 cycles during data bit 4 of 0xFF. Outputs return to reset values asynchronously. The next frame 0x81 is received correctly.
6. **Stream.** "Hello World!\n" (13 bytes) back-to-back with one stop bit each. All 13 bytes arrive in order with no errors.
